// File: rtl/avalon_pkg.sv
// Shared types and constants for the arbitrated Avalon-MM master.
package avalon_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} av_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // $clog2 that never returns a zero width
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: fixed priority (index 0 highest) or round-robin
// starting one past the last grant.
module rr_arbiter
  import avalon_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned MODE = ARB_RR,
  localparam int unsigned PTR_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (MODE == ARB_FIXED) ? PTR_W'(i) : PTR_W'((32'(last) + 32'd1 + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_mm_arb_master.sv
// N-requester Avalon-MM master: arbitrates valid/done requesters onto one bus
// port with LOCK sequences and a waitrequest timeout.
module avalon_mm_arb_master
  import avalon_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rnw,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         ADDRESS,
  output logic                      BEGINTRANSFER,
  output logic                      READ,
  output logic                      WRITE,
  output logic [DATA_W-1:0]         WRITEDATA,
  output logic                      LOCK,
  input  logic [DATA_W-1:0]         READDATA,
  input  logic                      WAITREQUEST
);

  localparam int unsigned      PTR_W     = clog2_min1(NUM_REQ);
  localparam int unsigned      CNT_W     = clog2_min1(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

  av_state_t           state_q, state_d;
  logic [PTR_W-1:0]    gnt_q, gnt_d, last_q, last_d, owner_q, owner_d, gnt_idx_c;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                lock_req_q, lock_req_d, locked_q, locked_d;
  logic [NUM_REQ-1:0]  arb_req, gnt_oh, done_d, err_d;
  logic [DATA_W-1:0]   rdata_d, wdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                busy_d, bt_d, read_d, write_d, lock_d;

  // While locked only the owner may win arbitration
  assign arb_req = locked_q ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;

  rr_arbiter #(.N(NUM_REQ), .MODE(ARB_MODE)) u_arb (
    .req  (arb_req),
    .last (last_q),
    .gnt  (gnt_oh)
  );

  always_comb begin
    gnt_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) gnt_idx_c = PTR_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    lock_req_d = lock_req_q;
    locked_d   = locked_q;
    done_d     = '0;
    err_d      = '0;
    rdata_d    = req_rdata;
    busy_d     = busy;
    addr_d     = ADDRESS;
    wdata_d    = WRITEDATA;
    bt_d       = 1'b0;
    read_d     = READ;
    write_d    = WRITE;
    lock_d     = LOCK;
    case (state_q)
      IDLE: begin
        if (|arb_req) begin
          gnt_d      = gnt_idx_c;
          last_d     = gnt_idx_c;
          addr_d     = req_addr[int'(gnt_idx_c) * ADDR_W +: ADDR_W];
          wdata_d    = req_wdata[int'(gnt_idx_c) * DATA_W +: DATA_W];
          read_d     = req_rnw[gnt_idx_c];
          write_d    = ~req_rnw[gnt_idx_c];
          bt_d       = 1'b1;
          lock_req_d = req_lock[gnt_idx_c];
          lock_d     = req_lock[gnt_idx_c] | locked_q;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (!WAITREQUEST) begin
          read_d        = 1'b0;
          write_d       = 1'b0;
          rdata_d       = READ ? READDATA : '0;
          done_d[gnt_q] = 1'b1;
          locked_d      = lock_req_q;
          lock_d        = lock_req_q;
          if (lock_req_q) owner_d = gnt_q;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
            read_d        = 1'b0;
            write_d       = 1'b0;
            rdata_d       = '1;
            done_d[gnt_q] = 1'b1;
            err_d[gnt_q]  = 1'b1;
            locked_d      = 1'b0;
            lock_d        = 1'b0;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_q        <= PTR_RST;
      owner_q       <= '0;
      cnt_q         <= '0;
      lock_req_q    <= 1'b0;
      locked_q      <= 1'b0;
      req_done      <= '0;
      req_err       <= '0;
      req_rdata     <= '0;
      busy          <= 1'b0;
      ADDRESS       <= '0;
      BEGINTRANSFER <= 1'b0;
      READ          <= 1'b0;
      WRITE         <= 1'b0;
      WRITEDATA     <= '0;
      LOCK          <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      lock_req_q    <= lock_req_d;
      locked_q      <= locked_d;
      req_done      <= done_d;
      req_err       <= err_d;
      req_rdata     <= rdata_d;
      busy          <= busy_d;
      ADDRESS       <= addr_d;
      BEGINTRANSFER <= bt_d;
      READ          <= read_d;
      WRITE         <= write_d;
      WRITEDATA     <= wdata_d;
      LOCK          <= lock_d;
    end
  end

endmodule

// File: tb/tb_avalon_mm_arb_master.sv
// Directed bench for avalon_mm_arb_master: a round-robin and a fixed-priority
// instance share all inputs; each exposes its own outputs.
module tb_avalon_mm_arb_master;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic [N-1:0]    req_valid, req_rnw, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   READDATA;
  logic            WAITREQUEST;

  logic [N-1:0]  rr_done, rr_err, fx_done, fx_err;
  logic [DW-1:0] rr_rdata, fx_rdata, rr_wd, fx_wd;
  logic [AW-1:0] rr_addr, fx_addr;
  logic          rr_busy, rr_bt, rr_read, rr_write, rr_lock;
  logic          fx_busy, fx_bt, fx_read, fx_write, fx_lock;

  always #5 CLK = ~CLK;

  avalon_mm_arb_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(8)) dut_rr (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_rnw(req_rnw), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(rr_done), .req_err(rr_err),
    .req_rdata(rr_rdata), .busy(rr_busy), .ADDRESS(rr_addr), .BEGINTRANSFER(rr_bt),
    .READ(rr_read), .WRITE(rr_write), .WRITEDATA(rr_wd), .LOCK(rr_lock),
    .READDATA(READDATA), .WAITREQUEST(WAITREQUEST)
  );

  avalon_mm_arb_master #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_fx (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_rnw(req_rnw), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(fx_done), .req_err(fx_err),
    .req_rdata(fx_rdata), .busy(fx_busy), .ADDRESS(fx_addr), .BEGINTRANSFER(fx_bt),
    .READ(fx_read), .WRITE(fx_write), .WRITEDATA(fx_wd), .LOCK(fx_lock),
    .READDATA(READDATA), .WAITREQUEST(WAITREQUEST)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  rnw;
    logic        wr;
    logic [31:0] rd;
    logic [3:0]  ctl_e;   // {READ, WRITE, BEGINTRANSFER, busy}
    logic [2:0]  done_e;
    logic [31:0] addr_e;
    logic [31:0] wd_e;
    logic [31:0] rdata_e;
    logic        chk_rd;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] rnw, input logic wr,
                              input logic [31:0] rd, input logic [3:0] ctl, input logic [2:0] done,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input logic chk_rd);
    vec_t r;
    r.valid = v; r.rnw = rnw; r.wr = wr; r.rd = rd; r.ctl_e = ctl; r.done_e = done;
    r.addr_e = addr; r.wd_e = wd; r.rdata_e = rdata; r.chk_rd = chk_rd;
    return r;
  endfunction

  function automatic int addr2idx(input logic [31:0] a);
    case (a)
      32'h40:  return 0;
      32'h100: return 1;
      32'h200: return 2;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    req_valid = '0; req_rnw = '0; req_lock = '0;
    WAITREQUEST = 1'b0; READDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic check_dut(input string tag, input int idx, input vec_t v,
                           input logic rd, input logic wr, input logic bt, input logic bsy,
                           input logic lck, input logic [2:0] done, input logic [2:0] err,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata);
    check($sformatf("%s[%0d] READ", tag, idx), 32'(rd), 32'(v.ctl_e[3]));
    check($sformatf("%s[%0d] WRITE", tag, idx), 32'(wr), 32'(v.ctl_e[2]));
    check($sformatf("%s[%0d] BEGINTRANSFER", tag, idx), 32'(bt), 32'(v.ctl_e[1]));
    check($sformatf("%s[%0d] busy", tag, idx), 32'(bsy), 32'(v.ctl_e[0]));
    check($sformatf("%s[%0d] LOCK", tag, idx), 32'(lck), 32'd0);
    check($sformatf("%s[%0d] req_done", tag, idx), 32'(done), 32'(v.done_e));
    check($sformatf("%s[%0d] req_err", tag, idx), 32'(err), 32'd0);
    if (v.ctl_e[3] || v.ctl_e[2]) check($sformatf("%s[%0d] ADDRESS", tag, idx), addr, v.addr_e);
    if (v.ctl_e[2]) check($sformatf("%s[%0d] WRITEDATA", tag, idx), wd, v.wd_e);
    if (v.chk_rd) check($sformatf("%s[%0d] req_rdata", tag, idx), rdata, v.rdata_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int rr_order[$], fx_order[$], rr_cyc[$];
    logic exp_lock[11];
    int hi;
    bit got;

    req_addr  = {32'h200, 32'h100, 32'h40};
    req_wdata = {32'h22222222, 32'h11111111, 32'h12345678};

    // Single read (0 waits) by req 1, then write by req 0 with 3 wait states
    vecs[0]  = mk(3'b010, 3'b010, 1'b0, 32'h0,        4'b0000, 3'b000, 32'h0,   32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(3'b010, 3'b010, 1'b0, 32'hCAFEF00D, 4'b1011, 3'b000, 32'h100, 32'h0,        32'h0,        1'b0);
    vecs[2]  = mk(3'b010, 3'b010, 1'b0, 32'h0,        4'b0001, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b1);
    vecs[3]  = mk(3'b000, 3'b000, 1'b0, 32'h0,        4'b0000, 3'b000, 32'h0,   32'h0,        32'h0,        1'b0);
    vecs[4]  = mk(3'b001, 3'b000, 1'b0, 32'h0,        4'b0000, 3'b000, 32'h0,   32'h0,        32'h0,        1'b0);
    vecs[5]  = mk(3'b001, 3'b000, 1'b1, 32'h0,        4'b0111, 3'b000, 32'h40,  32'h12345678, 32'h0,        1'b0);
    vecs[6]  = mk(3'b001, 3'b000, 1'b1, 32'h0,        4'b0101, 3'b000, 32'h40,  32'h12345678, 32'h0,        1'b0);
    vecs[7]  = mk(3'b001, 3'b000, 1'b1, 32'h0,        4'b0101, 3'b000, 32'h40,  32'h12345678, 32'h0,        1'b0);
    vecs[8]  = mk(3'b001, 3'b000, 1'b0, 32'h0,        4'b0101, 3'b000, 32'h40,  32'h12345678, 32'h0,        1'b0);
    vecs[9]  = mk(3'b001, 3'b000, 1'b0, 32'h0,        4'b0001, 3'b001, 32'h0,   32'h0,        32'h0,        1'b0);
    vecs[10] = mk(3'b000, 3'b000, 1'b0, 32'h0,        4'b0000, 3'b000, 32'h0,   32'h0,        32'h0,        1'b0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid; req_rnw = vecs[i].rnw;
      WAITREQUEST = vecs[i].wr; READDATA = vecs[i].rd;
      @(negedge CLK);
      check_dut("rr", i, vecs[i], rr_read, rr_write, rr_bt, rr_busy, rr_lock, rr_done, rr_err,
                rr_addr, rr_wd, rr_rdata);
      check_dut("fx", i, vecs[i], fx_read, fx_write, fx_bt, fx_busy, fx_lock, fx_done, fx_err,
                fx_addr, fx_wd, fx_rdata);
      next_cycle();
    end

    // All requesters valid continuously: RR rotates, fixed stays on 0
    do_reset();
    req_valid = 3'b111; req_rnw = 3'b111;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (rr_bt) begin rr_order.push_back(addr2idx(rr_addr)); rr_cyc.push_back(c); end
      if (fx_bt) fx_order.push_back(addr2idx(fx_addr));
      next_cycle();
    end
    check("rr grant count", 32'(rr_order.size()), 32'd4);
    check("fx grant count", 32'(fx_order.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr grant %0d", k), 32'((k < rr_order.size()) ? rr_order[k] : 99), 32'(k % 3));
      check($sformatf("rr grant cycle %0d", k), 32'((k < rr_cyc.size()) ? rr_cyc[k] : 99), 32'(1 + 3 * k));
      check($sformatf("fx grant %0d", k), 32'((k < fx_order.size()) ? fx_order[k] : 99), 32'd0);
    end

    // Lock sequence by req 2 while 0/1 pend
    do_reset();
    exp_lock = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    req_rnw = 3'b111;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin req_valid = 3'b100; req_lock = 3'b100; end
      if (c == 3) req_valid = 3'b111;
      if (c == 5) req_lock = 3'b000;
      if (c == 9) req_valid = 3'b011;
      @(negedge CLK);
      check($sformatf("lock LOCK c%0d", c), 32'(rr_lock), 32'(exp_lock[c]));
      if (c == 1 || c == 4 || c == 7 || c == 10) begin
        check($sformatf("lock BEGINTRANSFER c%0d", c), 32'(rr_bt), 32'd1);
        check($sformatf("lock ADDRESS c%0d", c), rr_addr, (c == 10) ? 32'h40 : 32'h200);
      end
      if (c == 8) check("lock final req_done", 32'(rr_done), 32'b100);
      next_cycle();
    end

    // Waitrequest stuck high with TIMEOUT=8
    do_reset();
    req_valid = 3'b001; req_rnw = 3'b001; req_lock = 3'b001;
    WAITREQUEST = 1'b1; READDATA = 32'h5A5A5A5A;
    hi = 0; got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (rr_read) begin
        hi++;
        check($sformatf("timeout LOCK during stall c%0d", c), 32'(rr_lock), 32'd1);
      end
      if (rr_done != 3'b000 && !got) begin
        got = 1'b1;
        check("timeout READ high cycles", 32'(hi), 32'd8);
        check("timeout req_done", 32'(rr_done), 32'b001);
        check("timeout req_err", 32'(rr_err), 32'b001);
        check("timeout req_rdata", rr_rdata, 32'hFFFFFFFF);
        check("timeout READ dropped", 32'(rr_read), 32'd0);
        check("timeout LOCK released", 32'(rr_lock), 32'd0);
      end
      next_cycle();
      if (got) req_valid = 3'b000;
    end
    check("timeout completion seen", 32'(got), 32'd1);

    // Asynchronous reset in the middle of a stalled transfer
    do_reset();
    req_valid = 3'b010; req_rnw = 3'b011; req_lock = 3'b000; WAITREQUEST = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    check("abort READ before reset", 32'(rr_read), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("abort READ", 32'(rr_read), 32'd0);
    check("abort busy", 32'(rr_busy), 32'd0);
    check("abort ADDRESS", rr_addr, 32'h0);
    check("abort BEGINTRANSFER", 32'(rr_bt), 32'd0);
    check("abort req_done", 32'(rr_done), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check("abort req_done in reset", 32'(rr_done), 32'd0);
    end
    next_cycle();
    RST_N = 1'b1; req_valid = 3'b011; WAITREQUEST = 1'b0; READDATA = 32'h77;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (rr_bt && !got) begin
        got = 1'b1;
        check("post-reset first grant ADDRESS", rr_addr, 32'h40);
      end
      if (rr_done != 3'b000 && c < 3) check("post-reset first req_done", 32'(rr_done), 32'b001);
      next_cycle();
    end
    check("post-reset grant seen", 32'(got), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
